// File: rtl/cla_nibble_sequencer_pkg.sv
// Shared types and constants for the nibble-serial carry-lookahead add sequencer.
package cla_nibble_sequencer_pkg;

  localparam int NIBBLES_DEFAULT = 4;
  localparam int NIBBLE_W        = 4;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Index register width; a single-nibble operand still gets a 1-bit index.
  function automatic int idx_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla_nibble_sequencer.sv
// Walks two W-bit operands one nibble at a time through an external registered
// 4-bit CLA stage, chaining the carry and assembling the {carry_out, sum} result.
module cla_nibble_sequencer
  import cla_nibble_sequencer_pkg::*;
#(
  parameter int NIBBLES = NIBBLES_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NIBBLE_W*NIBBLES-1:0]   a_in,
  input  logic [NIBBLE_W*NIBBLES-1:0]   b_in,
  input  logic                          cin,
  output logic                          busy,
  output logic                          done,
  output logic [NIBBLE_W*NIBBLES:0]     sum,
  output logic                          stg_enable,
  output logic [NIBBLE_W-1:0]           stg_a,
  output logic [NIBBLE_W-1:0]           stg_b,
  output logic                          stg_cin,
  input  logic [NIBBLE_W:0]             stg_q
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);

  state_t             r_state;
  state_t             w_next_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [W:0]         r_sum;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic               w_last;

  assign w_last = (r_idx == IDX_W'(NIBBLES - 1));
  assign sum    = r_sum;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one ISSUE/CAPTURE pair per nibble, then a single DONE cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    w_next_state = start ? ST_ISSUE : ST_IDLE;
      ST_ISSUE:   w_next_state = ST_CAPTURE;
      ST_CAPTURE: w_next_state = w_last ? ST_DONE : ST_ISSUE;
      ST_DONE:    w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // Current operand nibble selected by the running index.
  always_comb begin
    w_a_nib = {NIBBLE_W{1'b0}};
    w_b_nib = {NIBBLE_W{1'b0}};
    for (int k = 0; k < NIBBLES; k++) begin
      w_a_nib = (r_idx == IDX_W'(k)) ? r_a[k*NIBBLE_W +: NIBBLE_W] : w_a_nib;
      w_b_nib = (r_idx == IDX_W'(k)) ? r_b[k*NIBBLE_W +: NIBBLE_W] : w_b_nib;
    end
  end

  // Output decode; the stage bus is held at zero except while issuing.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    stg_enable = 1'b0;
    stg_a      = {NIBBLE_W{1'b0}};
    stg_b      = {NIBBLE_W{1'b0}};
    stg_cin    = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        busy       = 1'b1;
        stg_enable = 1'b1;
        stg_a      = w_a_nib;
        stg_b      = w_b_nib;
        stg_cin    = r_carry;
      end
      ST_CAPTURE: busy = 1'b1;
      ST_DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Operand latch, running carry, nibble index and result assembly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_carry <= 1'b0;
      r_idx   <= {IDX_W{1'b0}};
      r_sum   <= {(W+1){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_a     <= a_in;
            r_b     <= b_in;
            r_carry <= cin;
            r_idx   <= {IDX_W{1'b0}};
            r_sum   <= {(W+1){1'b0}};
          end
        end
        ST_CAPTURE: begin
          for (int k = 0; k < NIBBLES; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_sum[k*NIBBLE_W +: NIBBLE_W] <= stg_q[NIBBLE_W-1:0];
            end
          end
          r_carry <= stg_q[NIBBLE_W];
          if (w_last) begin
            r_sum[W] <= stg_q[NIBBLE_W];
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: begin
          r_carry <= r_carry;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Self-checking bench: models the external registered CLA stage and compares
// results, latency and stage-bus traffic against plain-arithmetic expectations.
module tb_cla_nibble_sequencer;

  localparam int NIB = 4;
  localparam int W   = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  a_in = '0;
  logic [W-1:0]  b_in = '0;
  logic          cin = 1'b0;
  logic          busy, done, stg_enable, stg_cin;
  logic [W:0]    sum;
  logic [3:0]    stg_a, stg_b;
  logic [4:0]    stg_q;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cla_nibble_sequencer #(.NIBBLES(NIB)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(a_in), .b_in(b_in), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .stg_enable(stg_enable),
    .stg_a(stg_a), .stg_b(stg_b), .stg_cin(stg_cin), .stg_q(stg_q)
  );

  // Downstream registered 4-bit adder stage.
  always @(posedge clk or posedge reset) begin
    if (reset) stg_q <= 5'd0;
    else if (stg_enable) stg_q <= {1'b0, stg_a} + {1'b0, stg_b} + {4'd0, stg_cin};
  end

  function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    int unsigned t;
    t = int'(a) + int'(b) + int'(c);
    return t[W:0];
  endfunction

  // Carry entering nibble k: overflow of the low 4k bits of the full addition.
  function automatic logic carry_into(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input int k);
    int unsigned mask, lo;
    if (k == 0) return c;
    mask = (32'd1 << (4*k)) - 32'd1;
    lo = (int'(a) & mask) + (int'(b) & mask) + int'(c);
    return lo[4*k];
  endfunction

  function automatic logic [9:0] all_zero_vec();
    return 10'd0;
  endfunction

  task automatic check_all_zero(input string name);
    logic [W+10:0] obs;
    obs = {busy, done, stg_enable, stg_a, stg_b, stg_cin, sum};
    n_cmp++;
    if (obs !== '0) begin
      n_err++;
      $display("FAIL %s: outputs=%h required all zero", name, obs);
    end
  endtask

  // One add; poke_at>=2 re-pulses start with different operands at that sample point.
  task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int poke_at, input string name);
    logic [W:0] exp;
    logic [9:0] exp_stg, obs_stg;
    logic [W-1:0] sh_a, sh_b;
    bit seen;
    int k;
    exp = ref_sum(a, b, c);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    seen = 1'b0;
    for (int n = 1; n <= 40 && !seen; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 1'b0;
        a_in = W'($urandom); b_in = W'($urandom); cin = 1'($urandom_range(0, 1));
        n_cmp++;
        if (sum !== '0 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL %s accept: sum=%h busy=%b required sum=0 busy=1", name, sum, busy);
        end
      end
      if (n == poke_at) begin
        start = 1'b1; a_in = ~a; b_in = 16'hFFFF; cin = ~c;
      end else if (n == poke_at + 1) begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        n_cmp++;
        if (n != 2*NIB + 1) begin
          n_err++;
          $display("FAIL %s latency: done after %0d cycles required %0d", name, n, 2*NIB + 1);
        end
        n_cmp++;
        if (sum !== exp) begin
          n_err++;
          $display("FAIL %s sum: got %h required %h", name, sum, exp);
        end
      end else if (n <= 2*NIB) begin
        k = (n - 1) / 2;
        if (n % 2 == 1) begin
          sh_a = a >> (4*k);
          sh_b = b >> (4*k);
          exp_stg = {1'b1, sh_a[3:0], sh_b[3:0], carry_into(a, b, c, k)};
        end else begin
          exp_stg = all_zero_vec();
        end
        obs_stg = {stg_enable, stg_a, stg_b, stg_cin};
        n_cmp++;
        if (obs_stg !== exp_stg) begin
          n_err++;
          $display("FAIL %s stage n=%0d: got %h required %h", name, n, obs_stg, exp_stg);
        end
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s timeout: done not seen within 40 cycles required by cycle %0d", name, 2*NIB + 1);
    end
    @(posedge clk);
    start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || sum !== exp) begin
      n_err++;
      $display("FAIL %s after-done: done=%b sum=%h required done=0 sum=%h", name, done, sum, exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_all_zero("reset_state");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_directed();
    do_add(16'h1234, 16'h4321, 1'b0, 0, "add_1234_4321");
    do_add(16'hFFFF, 16'h0001, 1'b0, 0, "ripple_ffff_0001");
    do_add(16'hFFFF, 16'hFFFF, 1'b1, 0, "max_with_cin");
  endtask

  task automatic test_ignore_busy();
    do_add(16'h0001, 16'h0001, 1'b0, 3, "start_while_busy");
    do_add(16'h0F00, 16'h0100, 1'b1, 6, "start_while_capture");
    do_add(16'hA5A5, 16'h5A5A, 1'b0, 9, "start_while_done");
  endtask

  task automatic test_reset_mid();
    a_in = 16'h1111; b_in = 16'h2222; cin = 1'b0; start = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    #1;
    check_all_zero("reset_mid_capture");
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL reset_no_done: done=%b required 0", done);
      end
      if (n == 3) reset = 1'b0;
    end
    do_add(16'h0F0F, 16'h00F1, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    do_add(16'h0123, 16'h0456, 1'b1, 0, "b2b_first");
    do_add(16'h8000, 16'h8000, 1'b0, 0, "b2b_second");
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    logic c;
    int poke;
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      c = 1'($urandom_range(0, 1));
      poke = (i % 3 == 0) ? int'($urandom_range(2, 9)) : 0;
      do_add(a, b, c, poke, "random_add");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_nibble_sequencer.md
CLA_NIBBLE_SEQUENCER -- requirements
Module: cla_nibble_sequencer

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1: request an add; sampled only in IDLE.
REQ-005 SHALL have port a_in, input, W: operand A.
REQ-006 SHALL have port b_in, input, W: operand B.
REQ-007 SHALL have port cin, input, 1: carry into nibble 0.
REQ-008 SHALL have port busy, output, 1: high in ISSUE and CAPTURE.
REQ-009 SHALL have port done, output, 1: one-cycle pulse, sum valid.
REQ-010 SHALL have port sum, output, W+1: {carry_out, sum bits}, held until next accepted start.
REQ-011 SHALL have port stg_enable, output, 1: enable to downstream 4-bit CLA_4bits stage.
REQ-012 SHALL have port stg_a, output, 4: current A nibble.
REQ-013 SHALL have port stg_b, output, 4: current B nibble.
REQ-014 SHALL have port stg_cin, output, 1: carry into current nibble.
REQ-015 SHALL have port stg_q, input, 5: registered stage result {Cout, S}, valid the cycle after stg_enable.

Function
REQ-016 SHALL implement states IDLE, ISSUE, CAPTURE, DONE.
REQ-017 IDLE: start=1 SHALL latch a_in, b_in, cin, clear nibble index to 0, go to ISSUE; start=0 stays IDLE.
REQ-018 ISSUE SHALL drive stg_enable=1, stg_a/stg_b = latched operand nibble[idx], stg_cin = running carry; next state CAPTURE.
REQ-019 CAPTURE SHALL drive stg_enable=0, write stg_q[3:0] into sum nibble[idx], load stg_q[4] into running carry.
REQ-020 CAPTURE with idx < NIBBLES-1 SHALL increment idx and return to ISSUE; with idx = NIBBLES-1 SHALL write stg_q[4] into sum[W] and go to DONE.
REQ-021 DONE SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-022 Latency SHALL be: start sampled at edge t -> done high in cycle between edges t+2*NIBBLES and t+2*NIBBLES+1 (cycle 9 after start for NIBBLES=4).
REQ-023 start while busy or in DONE SHALL be ignored; operands changing after acceptance SHALL not affect the result.
REQ-024 start in the cycle after done (IDLE) SHALL be accepted normally (back-to-back).
REQ-025 stg_a, stg_b, stg_cin SHALL be 0 outside ISSUE.
REQ-026 sum SHALL be cleared to 0 on accepted start and SHALL be stable while done is high and through following IDLE.
REQ-027 Result SHALL equal a_in + b_in + cin modulo 2^(W+1), no truncation.

Reset
REQ-028 reset high SHALL immediately force IDLE, busy=0, done=0, stg_enable=0, stg_a=stg_b=0, stg_cin=0, sum=0, idx=0, running carry=0.
REQ-029 reset mid-operation SHALL abandon the add with no done pulse; first start after reset release SHALL be handled normally.

Structure
REQ-030 Shared package SHALL hold the state enum, default NIBBLES, and the nibble-width constant 4.
REQ-031 No sub-module SHALL be instantiated; the CLA_4bits stage SHALL be instantiated alongside in the parent, with stg_* wired to its enable/A/B/Cin/Q.

Verification
REQ-032 0x1234 + 0x4321, cin=0 -> sum=0x05555, done exactly 9 cycles after start edge.
REQ-033 0xFFFF + 0x0001, cin=0 -> sum=0x10000 (carry ripples through all four nibbles).
REQ-034 0xFFFF + 0xFFFF, cin=1 -> sum=0x1FFFF.
REQ-035 Start 0x0001+0x0001, pulse start again with 0xFFFF+0xFFFF while busy -> second start ignored, sum=0x00002.
REQ-036 reset asserted in CAPTURE of nibble 2 -> all outputs 0 at once, no done; then 0x0F0F+0x00F1 -> sum=0x01000.
REQ-037 Back-to-back: start in cycle after done with 0x8000+0x8000 -> sum=0x10000, done 9 cycles later.
